// File: rtl/spi_reg_acc_pkg.sv
// Shared types and constants for the SPI register-access controller.
//   - state_t      : frame FSM states
//   - CRC defaults : CRC-8 polynomial (MSB-first) and per-frame seed
//   - bit indices  : R/W flag in CMD, status-byte error flags
package spi_reg_acc_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned RW_BIT      = 7;
    localparam int unsigned STS_FRM_BIT = 0;
    localparam int unsigned STS_CRC_BIT = 1;

    localparam logic [BYTE_W-1:0] CRC_POLY_DEF = 8'h07;
    localparam logic [BYTE_W-1:0] CRC_INIT_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_CRC,
        ST_EXEC,
        ST_TAIL
    } state_t;

    // Status byte returned in the CRC slot: sticky error flags, rest zero.
    function automatic logic [BYTE_W-1:0] status_byte(input logic crc_err, input logic frm_err);
        logic [BYTE_W-1:0] s;
        s              = '0;
        s[STS_FRM_BIT] = frm_err;
        s[STS_CRC_BIT] = crc_err;
        return s;
    endfunction

endpackage

// File: rtl/spi_reg_acc_ctrl_if.sv
// Bundle of byte-shifter and register-bank signals seen by the controller.
//   master : environment side (shifter + register bank), drives the i_* signals
//   slave  : controller side, drives the o_* signals
interface spi_reg_acc_ctrl_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8
);
    logic          i_cs_act;
    logic          i_rx_vld;
    logic [7:0]    i_rx_byte;
    logic [7:0]    o_tx_byte;
    logic          o_wen;
    logic          o_ren;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [DW-1:0] i_rdata;
    logic          o_crc_err;
    logic          o_frm_err;
    logic          o_busy;

    modport master (
        output i_cs_act, i_rx_vld, i_rx_byte, i_rdata,
        input  o_tx_byte, o_wen, o_ren, o_addr, o_wdata, o_crc_err, o_frm_err, o_busy
    );

    modport slave (
        input  i_cs_act, i_rx_vld, i_rx_byte, i_rdata,
        output o_tx_byte, o_wen, o_ren, o_addr, o_wdata, o_crc_err, o_frm_err, o_busy
    );
endinterface

// File: rtl/spi_reg_acc_ctrl_crc8_step.sv
// One-byte CRC-8 update, MSB-first, fully combinational.
//   crc_in  : current CRC
//   byte_in : byte to fold in
//   crc_out : CRC after all 8 bits of byte_in
module crc8_step
    import spi_reg_acc_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY_DEF
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);
    logic [7:0] c;

    always_comb begin
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/spi_reg_acc_ctrl.sv
// Frame-level register-access controller: decodes CMD/DATA/CRC frames from
// the SPI byte shifter into register read/write strobes and returns data.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : shifter inputs (cs, rx byte), register bank (strobes,
//                  address, write data, read data), tx byte, error pulses, busy
module spi_reg_acc_ctrl
    import spi_reg_acc_pkg::*;
#(
    parameter int unsigned AW       = 7,
    parameter int unsigned DW       = 8,
    parameter logic [7:0]  CRC_POLY = CRC_POLY_DEF,
    parameter logic [7:0]  CRC_INIT = CRC_INIT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    spi_reg_acc_ctrl_if.slave   bus
);
    state_t        state_q, state_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    tx_q, tx_d;
    logic          wen_q, wen_d;
    logic          ren_q, ren_d;
    logic          crc_err_q, crc_err_d;
    logic          frm_err_q, frm_err_d;
    logic [7:0]    crc_q, crc_d;
    logic          crc_sts_q, crc_sts_d;
    logic          frm_sts_q, frm_sts_d;
    logic          frame_ok_q, frame_ok_d;
    logic [7:0]    crc_nxt;

    crc8_step #(.POLY(CRC_POLY)) u_crc (
        .crc_in  (crc_q),
        .byte_in (bus.i_rx_byte),
        .crc_out (crc_nxt)
    );

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_q       <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            crc_q      <= CRC_INIT;
            crc_sts_q  <= 1'b0;
            frm_sts_q  <= 1'b0;
            frame_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            crc_err_q  <= crc_err_d;
            frm_err_q  <= frm_err_d;
            crc_q      <= crc_d;
            crc_sts_q  <= crc_sts_d;
            frm_sts_q  <= frm_sts_d;
            frame_ok_q <= frame_ok_d;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;
        crc_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        crc_d      = crc_q;
        crc_sts_d  = crc_sts_q;
        frm_sts_d  = frm_sts_q;
        frame_ok_d = frame_ok_q;

        unique case (state_q)
            ST_IDLE: begin
                crc_d      = CRC_INIT;
                frame_ok_d = 1'b0;
                if (bus.i_cs_act) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (!bus.i_cs_act) begin
                    frm_err_d = 1'b1;
                    frm_sts_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.i_rx_vld) begin
                    rw_d    = bus.i_rx_byte[RW_BIT];
                    addr_d  = bus.i_rx_byte[AW-1:0];
                    crc_d   = crc_nxt;
                    ren_d   = !bus.i_rx_byte[RW_BIT];
                    if (bus.i_rx_byte[RW_BIT]) tx_d = bus.i_rx_byte;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Read data is valid while the read strobe is out.
                if (ren_q) tx_d = DW'(bus.i_rdata);
                if (!bus.i_cs_act) begin
                    frm_err_d = 1'b1;
                    frm_sts_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.i_rx_vld) begin
                    if (rw_q) wdata_d = DW'(bus.i_rx_byte);
                    crc_d   = crc_nxt;
                    tx_d    = status_byte(crc_sts_q, frm_sts_q);
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                if (!bus.i_cs_act) begin
                    frm_err_d = 1'b1;
                    frm_sts_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.i_rx_vld) begin
                    if (bus.i_rx_byte == crc_q) begin
                        state_d = ST_EXEC;
                    end else begin
                        crc_err_d = 1'b1;
                        crc_sts_d = 1'b1;
                        state_d   = ST_TAIL;
                    end
                end
            end
            ST_EXEC: begin
                wen_d      = rw_q;
                frame_ok_d = 1'b1;
                state_d    = ST_TAIL;
            end
            ST_TAIL: begin
                if (!bus.i_cs_act) begin
                    // Clean frame: error history is cleared on completion.
                    if (frame_ok_q) begin
                        crc_sts_d = 1'b0;
                        frm_sts_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end else if (bus.i_rx_vld) begin
                    frm_err_d  = 1'b1;
                    frm_sts_d  = 1'b1;
                    frame_ok_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_tx_byte = tx_q;
    assign bus.o_wen     = wen_q;
    assign bus.o_ren     = ren_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_wdata   = wdata_q;
    assign bus.o_crc_err = crc_err_q;
    assign bus.o_frm_err = frm_err_q;
    assign bus.o_busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_spi_reg_acc_ctrl.sv
// Bench for spi_reg_acc_ctrl: directed frames, frame-level expectation model,
// per-cycle comparison of all DUT outputs on the falling clock edge.
module tb_spi_reg_acc_ctrl;
    import spi_reg_acc_pkg::*;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    spi_reg_acc_ctrl_if #(.AW(7), .DW(8)) sif ();

    spi_reg_acc_ctrl #(.AW(7), .DW(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    // Register bank stand-in: returns stored data while the read strobe is out.
    bit [7:0] bank [128];
    assign sif.i_rdata = sif.o_ren ? bank[sif.o_addr] : 8'h00;
    always @(posedge clk) if (sif.o_wen) bank[sif.o_addr] <= sif.o_wdata;

    // Expectations indexed by the clock edge after which they must be visible.
    bit       exp_wen  [MAXC];
    bit       exp_ren  [MAXC];
    bit       exp_cerr [MAXC];
    bit       exp_ferr [MAXC];
    bit [6:0] exp_addr [MAXC];
    bit [7:0] exp_wdat [MAXC];
    bit       tx_chk   [MAXC];
    bit [7:0] exp_tx   [MAXC];
    bit       cs_at    [MAXC];
    bit       rst_at   [MAXC];

    bit [7:0] model_mem [128];
    bit       sts_crc = 1'b0;
    bit       sts_frm = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < MAXC) begin
            cs_at[cyc+1]  <= sif.i_cs_act;
            rst_at[cyc+1] <= rst;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // CRC as the remainder of {CMD,DATA} * x^8 modulo the generator polynomial.
    function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
        logic [23:0] m;
        m = {c ^ CRC_INIT_DEF, d, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (m[i]) m[i -: 9] = m[i -: 9] ^ {1'b1, CRC_POLY_DEF};
        end
        return m[7:0];
    endfunction

    // Output comparison against the model, every cycle after the first edge.
    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            if (rst_at[cyc]) begin
                chk("rst_tx",    32'(sif.o_tx_byte), 32'h0);
                chk("rst_addr",  32'(sif.o_addr),    32'h0);
                chk("rst_wdata", 32'(sif.o_wdata),   32'h0);
            end else if (tx_chk[cyc]) begin
                chk("tx_byte", 32'(sif.o_tx_byte), 32'(exp_tx[cyc]));
            end
            chk("wen",     32'(sif.o_wen),     32'(exp_wen[cyc]));
            chk("ren",     32'(sif.o_ren),     32'(exp_ren[cyc]));
            chk("crc_err", 32'(sif.o_crc_err), 32'(exp_cerr[cyc]));
            chk("frm_err", 32'(sif.o_frm_err), 32'(exp_ferr[cyc]));
            chk("busy",    32'(sif.o_busy),    32'(cs_at[cyc] & ~rst_at[cyc]));
            if (exp_wen[cyc]) begin
                chk("wr_addr",  32'(sif.o_addr),  32'(exp_addr[cyc]));
                chk("wr_wdata", 32'(sif.o_wdata), 32'(exp_wdat[cyc]));
            end
            if (exp_ren[cyc]) chk("rd_addr", 32'(sif.o_addr), 32'(exp_addr[cyc]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_cs(input logic v);
        @(posedge clk); #1;
        sif.i_cs_act = v;
    endtask

    // One-cycle rx_vld pulse; e = edge at which the DUT samples it.
    task automatic send(input logic [7:0] b, output int e);
        @(posedge clk); #1;
        sif.i_rx_vld  = 1'b1;
        sif.i_rx_byte = b;
        e = cyc + 1;
        @(posedge clk); #1;
        sif.i_rx_vld = 1'b0;
    endtask

    // Frame of n bytes (n<3 aborts by dropping CS, n>3 adds trailing bytes).
    task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bytes [4];
        int         e;
        bit         ok;
        logic [6:0] a;
        bytes = '{b0, b1, b2, b3};
        a  = bytes[0][6:0];
        ok = 1'b0;
        set_cs(1'b1);
        idle(2);
        for (int i = 0; i < n; i++) begin
            send(bytes[i], e);
            case (i)
                0: begin
                    if (bytes[0][7]) begin
                        tx_chk[e] = 1'b1; exp_tx[e] = bytes[0];
                    end else begin
                        exp_ren[e] = 1'b1; exp_addr[e] = a;
                        tx_chk[e+1] = 1'b1; exp_tx[e+1] = model_mem[a];
                    end
                end
                1: begin
                    tx_chk[e] = 1'b1;
                    exp_tx[e] = {6'b0, sts_crc, sts_frm};
                end
                2: begin
                    if (bytes[2] == crc_model(bytes[0], bytes[1])) begin
                        ok = 1'b1;
                        if (bytes[0][7]) begin
                            exp_wen[e+1] = 1'b1; exp_addr[e+1] = a; exp_wdat[e+1] = bytes[1];
                            model_mem[a] = bytes[1];
                        end
                    end else begin
                        exp_cerr[e] = 1'b1;
                        sts_crc     = 1'b1;
                    end
                end
                default: begin
                    exp_ferr[e] = 1'b1;
                    sts_frm     = 1'b1;
                    ok          = 1'b0;
                end
            endcase
            idle(3);
        end
        @(posedge clk); #1;
        sif.i_cs_act = 1'b0;
        e = cyc + 1;
        if (n < 3) begin
            exp_ferr[e] = 1'b1;
            sts_frm     = 1'b1;
        end else if (ok) begin
            sts_crc = 1'b0;
            sts_frm = 1'b0;
        end
        idle(3);
    endtask

    initial begin
        int e;
        sif.i_cs_act  = 1'b0;
        sif.i_rx_vld  = 1'b0;
        sif.i_rx_byte = 8'h00;
        rst = 1'b1;
        idle(3);
        #1 rst = 1'b0;
        idle(2);

        chk("crc_pin_wr",  32'(crc_model(8'h81, 8'h8E)), 32'h00);
        chk("crc_pin_rd",  32'(crc_model(8'h01, 8'h07)), 32'h00);
        chk("crc_pin_zero", 32'(crc_model(8'h81, 8'h00)), 32'hA3);

        frame(3, 8'h81, 8'h8E, 8'h00, 8'h00);
        chk("mem1_after_wr", 32'(model_mem[1]), 32'h8E);
        frame(3, 8'h01, 8'h07, 8'h00, 8'h00);
        frame(3, 8'h81, 8'h8E, 8'h01, 8'h00);
        chk("sts_bad_crc", 32'({sts_crc, sts_frm}), 32'h2);
        frame(3, 8'h81, 8'h00, 8'hA3, 8'h00);
        chk("sts_clean", 32'({sts_crc, sts_frm}), 32'h0);
        frame(2, 8'h81, 8'h55, 8'h00, 8'h00);

        // Byte while CS is inactive must be ignored.
        send(8'h81, e);
        idle(3);

        frame(4, 8'h85, 8'h3C, crc_model(8'h85, 8'h3C), 8'h33);
        chk("sts_extra", 32'({sts_crc, sts_frm}), 32'h1);
        frame(3, 8'h05, 8'h07, crc_model(8'h05, 8'h07), 8'h00);
        frame(3, 8'h01, 8'h07, 8'h55, 8'h00);

        // CS drop coinciding with a byte in CMD: abort wins, byte dropped.
        set_cs(1'b1);
        idle(2);
        @(posedge clk); #1;
        sif.i_cs_act  = 1'b0;
        sif.i_rx_vld  = 1'b1;
        sif.i_rx_byte = 8'h01;
        e = cyc + 1;
        exp_ferr[e] = 1'b1;
        sts_frm     = 1'b1;
        @(posedge clk); #1;
        sif.i_rx_vld = 1'b0;
        idle(3);
        chk("sts_abort_byte", 32'({sts_crc, sts_frm}), 32'h3);

        // Reset while the DATA byte is awaited.
        set_cs(1'b1);
        idle(2);
        send(8'h81, e);
        tx_chk[e] = 1'b1; exp_tx[e] = 8'h81;
        idle(2);
        @(posedge clk); #1;
        rst = 1'b1;
        sif.i_cs_act = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sts_crc = 1'b0;
        sts_frm = 1'b0;
        idle(3);

        frame(3, 8'h81, 8'h8E, 8'h00, 8'h00);
        frame(3, 8'h01, 8'h07, 8'h00, 8'h00);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
